cam_line_reader: RTL and testbench
==================================

Name: cam_line_reader

Overview:
- Receiving end of the linear CCD camera interface; runs on the same cam_clk that drives the SI pulse generator.
- Watches the SI pulse and captures one line of NPIX digitised pixel samples from the ADC into a ping-pong line buffer.
- Flags each completed line and lets the downstream track/steering logic read the completed bank while the next line is written.

Parameters:
- NPIX, 128, pixels per line.
- DW, 8, ADC sample width.
- SKIP, 1, cam_clk cycles ignored after the SI rising edge before the first pixel is accepted.
- TIMEOUT, 255, maximum consecutive cycles with adc_valid low during capture before the line is aborted.

Ports:
- cam_clk  input  1  camera/system clock.
- rst_n  input  1  asynchronous active-low reset.
- cam_si  input  1  SI pulse as driven to the sensor, high for one cam_clk.
- adc_valid  input  1  adc_data holds a new pixel sample this cycle.
- adc_data  input  DW  pixel sample.
- rd_addr  input  clog2(NPIX)  read address into the completed bank.
- rd_data  output  DW  pixel at rd_addr, registered.
- line_ready  output  1  one-cycle pulse when a bank completes and swaps.
- line_cnt  output  16  completed-line counter, wraps.
- abort_cnt  output  8  aborted-line counter, saturates at 255.
- busy  output  1  high while in SKIP or CAPTURE.

Behaviour:
- Reset values (async on rst_n low):
  - FSM state IDLE; write bank 0, read bank 1.
  - Pixel index 0, rd_data 0, line_ready 0, line_cnt 0, abort_cnt 0, busy 0.
  - Buffer contents undefined.
- SI edge detection: cam_si is registered once; the rising edge is cam_si high with the registered copy low.
- FSM:
  - IDLE: on SI edge go to SKIP, clear the skip counter. If SKIP=0, go straight to CAPTURE.
  - SKIP: count SKIP cycles, then CAPTURE with pixel index 0 and the timeout counter cleared.
  - CAPTURE:
    - adc_valid high: write adc_data at the current index in the write bank, increment the index, clear the timeout counter.
    - adc_valid low: index holds, timeout counter increments.
    - The write of index NPIX-1 moves to DONE.
  - DONE (one cycle): swap banks, pulse line_ready, increment line_cnt, return to IDLE.
- busy is high in SKIP and CAPTURE only.
- Boundary conditions:
  - SI edge during SKIP or CAPTURE: abort the current line, increment abort_cnt, restart in SKIP. The bank does not swap and the partial data stays in the write bank.
  - SI edge in the same cycle as DONE: DONE completes (swap and pulse), then SKIP is entered on the next cycle. The edge is latched, not lost.
  - Timeout counter reaches TIMEOUT: abort as above and return to IDLE.
  - adc_valid outside CAPTURE is ignored; no write occurs.
  - rd_addr >= NPIX: rd_data is 0.
- Read port:
  - One-cycle latency; rd_data registered from the read bank.
  - When rd_addr is held across a swap, rd_data changes to the new bank one cycle after line_ready.
  - The read bank is never written.
- Reset asserted mid-line: everything returns to reset values; no line_ready is generated.
- Index and counter widths: index is clog2(NPIX) bits with no wrap inside CAPTURE. line_cnt wraps 0xFFFF→0; abort_cnt saturates.

Optional Feature:
- Macro: CAM_MINMAX_EN.
- Defined:
  - Adds outputs pix_min (DW), pix_max (DW) and thresh (DW).
  - A running min/max is updated on every accepted pixel and reset at the start of CAPTURE.
  - On DONE, pix_min and pix_max are latched from the running values, and thresh is latched as (pix_min+pix_max)>>1 using a DW+1-bit sum.
  - All three hold until the next DONE and reset to 0.
  - Aborted lines do not update them.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic line: reset, SI pulse, then 128 consecutive adc_valid cycles with adc_data=index → line_ready pulses on cycle SKIP+1+128+1 after the SI edge. Reading rd_addr 0..127 returns 0..127 at 1-cycle latency; line_cnt=1.
- Gaps: same line with adc_valid low every third cycle → same buffer contents; line_ready delayed by the number of gap cycles; abort_cnt=0.
- Early SI: second SI edge after 60 pixels → abort_cnt=1, no line_ready. The following full line (data 0xFF) completes, and reading returns 0xFF with line_cnt=1.
- Timeout: stop adc_valid after 10 pixels for 255 cycles → abort_cnt=1, busy=0, FSM in IDLE. The next SI edge starts a clean capture.
- Ping-pong: capture line A (0x11), start line B (0x22) while holding rd_addr=5 → rd_data stays 0x11 during B capture and becomes 0x22 one cycle after B's line_ready. Reset asserted mid-line B → all outputs 0.
- CAM_MINMAX_EN: line with samples 0x10..0x8F → pix_min=0x10, pix_max=0x8F, thresh=0x4F; an aborted line leaves them unchanged.

Source files
------------

// File: rtl/cam_line_reader.sv
// cam_line_reader: captures one CCD line per SI pulse into a ping-pong buffer.
// Optional running min/max/threshold outputs are enabled with CAM_MINMAX_EN.
module cam_line_reader #(
    parameter int NPIX    = 128,
    parameter int DW      = 8,
    parameter int SKIP    = 1,
    parameter int TIMEOUT = 255,
    localparam int AW     = $clog2(NPIX)
) (
    input  logic          cam_clk,
    input  logic          rst_n,
    input  logic          cam_si,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          line_ready,
    output logic [15:0]   line_cnt,
    output logic [7:0]    abort_cnt,
    output logic          busy
`ifdef CAM_MINMAX_EN
    ,
    output logic [DW-1:0] pix_min,
    output logic [DW-1:0] pix_max,
    output logic [DW-1:0] thresh
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SKIP = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int SCW  = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int SKM1 = (SKIP > 0) ? SKIP - 1 : 0;
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [SCW-1:0] SKIP_LAST = SCW'(SKM1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0]  IDX_LAST  = AW'(NPIX - 1);
    localparam logic [AW:0]    NPIX_W    = (AW + 1)'(NPIX);

    logic [1:0]     state_q, state_d;
    logic           si_q;
    logic           si_edge;
    logic           bank_q, bank_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [SCW-1:0] skip_q, skip_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [15:0]    line_cnt_q, line_cnt_d;
    logic [7:0]     abort_cnt_q, abort_cnt_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic [DW-1:0]  rd_data_q;
    logic           wr_en;
    logic           abort_inc;
    logic           start_line;
    logic           cap_start;

    // bank_q selects the write half; the read half is always the other one
    logic [DW-1:0]  mem [2**(AW+1)];

    assign si_edge = cam_si & ~si_q;

    // Next-state logic: line sequencing, aborts and completion
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        idx_d      = idx_q;
        skip_d     = skip_q;
        tmo_d      = tmo_q;
        line_cnt_d = line_cnt_q;
        ready_d    = 1'b0;
        wr_en      = 1'b0;
        abort_inc  = 1'b0;
        start_line = 1'b0;
        cap_start  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (si_edge) start_line = 1'b1;
            end
            S_SKIP: begin
                if (si_edge) begin
                    abort_inc  = 1'b1;
                    start_line = 1'b1;
                end else if (skip_q == SKIP_LAST) begin
                    state_d   = S_CAP;
                    idx_d     = '0;
                    tmo_d     = '0;
                    cap_start = 1'b1;
                end else begin
                    skip_d = skip_q + 1'b1;
                end
            end
            S_CAP: begin
                if (si_edge) begin
                    abort_inc  = 1'b1;
                    start_line = 1'b1;
                end else if (adc_valid) begin
                    wr_en = 1'b1;
                    tmo_d = '0;
                    if (idx_q == IDX_LAST) state_d = S_DONE;
                    else idx_d = idx_q + 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    abort_inc = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                bank_d     = ~bank_q;
                ready_d    = 1'b1;
                line_cnt_d = line_cnt_q + 16'd1;
                state_d    = S_IDLE;
                // an SI edge here starts the next line right after the swap
                if (si_edge) start_line = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (start_line) begin
            skip_d = '0;
            idx_d  = '0;
            tmo_d  = '0;
            if (SKIP == 0) begin
                state_d   = S_CAP;
                cap_start = 1'b1;
            end else begin
                state_d = S_SKIP;
            end
        end
        abort_cnt_d = abort_cnt_q;
        if (abort_inc && abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
        busy_d = (state_d == S_SKIP) || (state_d == S_CAP);
    end

    // Control and status registers
    always_ff @(posedge cam_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            si_q        <= 1'b0;
            bank_q      <= 1'b0;
            idx_q       <= '0;
            skip_q      <= '0;
            tmo_q       <= '0;
            line_cnt_q  <= '0;
            abort_cnt_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            si_q        <= cam_si;
            bank_q      <= bank_d;
            idx_q       <= idx_d;
            skip_q      <= skip_d;
            tmo_q       <= tmo_d;
            line_cnt_q  <= line_cnt_d;
            abort_cnt_q <= abort_cnt_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // Pixel write into the current write bank
    always_ff @(posedge cam_clk) begin
        if (wr_en) mem[{bank_q, idx_q}] <= adc_data;
    end

    // Registered read from the completed bank; out-of-range reads return 0
    always_ff @(posedge cam_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr} < NPIX_W) begin
            rd_data_q <= mem[{~bank_q, rd_addr}];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data    = rd_data_q;
    assign line_ready = ready_q;
    assign line_cnt   = line_cnt_q;
    assign abort_cnt  = abort_cnt_q;
    assign busy       = busy_q;

`ifdef CAM_MINMAX_EN
    logic [DW-1:0] run_min_q, run_max_q;
    logic [DW-1:0] pix_min_q, pix_max_q, thresh_q;
    logic [DW:0]   mm_sum;

    assign mm_sum = {1'b0, run_min_q} + {1'b0, run_max_q};

    // Running extremes per line, latched only when a line completes
    always_ff @(posedge cam_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min_q <= '1;
            run_max_q <= '0;
            pix_min_q <= '0;
            pix_max_q <= '0;
            thresh_q  <= '0;
        end else begin
            if (cap_start) begin
                run_min_q <= '1;
                run_max_q <= '0;
            end else if (wr_en) begin
                if (adc_data < run_min_q) run_min_q <= adc_data;
                if (adc_data > run_max_q) run_max_q <= adc_data;
            end
            if (state_q == S_DONE) begin
                pix_min_q <= run_min_q;
                pix_max_q <= run_max_q;
                thresh_q  <= mm_sum[DW:1];
            end
        end
    end

    assign pix_min = pix_min_q;
    assign pix_max = pix_max_q;
    assign thresh  = thresh_q;
`endif

endmodule

// File: tb/tb_cam_line_reader.sv
// tb_cam_line_reader: random/directed line captures against a line-level model.
// Min/max checks are compiled in when CAM_MINMAX_EN is defined.
module tb_cam_line_reader;

    localparam int NPIX    = 128;
    localparam int DW      = 8;
    localparam int SKIP    = 1;
    localparam int TIMEOUT = 255;

    logic          cam_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cam_si = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic [6:0]    rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          line_ready;
    logic [15:0]   line_cnt;
    logic [7:0]    abort_cnt;
    logic          busy;
`ifdef CAM_MINMAX_EN
    logic [DW-1:0] pix_min, pix_max, thresh;
`endif

    cam_line_reader #(
        .NPIX(NPIX), .DW(DW), .SKIP(SKIP), .TIMEOUT(TIMEOUT)
    ) dut (
        .cam_clk(cam_clk),
        .rst_n(rst_n),
        .cam_si(cam_si),
        .adc_valid(adc_valid),
        .adc_data(adc_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .line_ready(line_ready),
        .line_cnt(line_cnt),
        .abort_cnt(abort_cnt),
        .busy(busy)
`ifdef CAM_MINMAX_EN
        ,
        .pix_min(pix_min),
        .pix_max(pix_max),
        .thresh(thresh)
`endif
    );

    always #5 cam_clk = ~cam_clk;

    int vecs = 0;
    int misses = 0;

    // Reference model, tracked in terms of "posedges since the starting SI edge".
    bit           m_si_prev;
    bit           m_active;
    int           m_age;
    int           m_nacc;
    int           m_lows;
    int           m_lines;
    int           m_aborts;
    bit           m_rd_known;
    logic [7:0]   m_buf [NPIX];
    logic [7:0]   m_rd [NPIX];
    int           m_min, m_max, m_thr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_si_prev  = 0;
        m_active   = 0;
        m_age      = 0;
        m_nacc     = 0;
        m_lows     = 0;
        m_lines    = 0;
        m_aborts   = 0;
        m_rd_known = 0;
        m_min      = 0;
        m_max      = 0;
        m_thr      = 0;
    endtask

    task automatic model_start();
        m_active = 1;
        m_age    = 0;
        m_nacc   = 0;
        m_lows   = 0;
    endtask

    task automatic model_abort();
        if (m_aborts < 255) m_aborts++;
    endtask

    // One posedge of the model; returns what the DUT should show after it.
    task automatic model_step(input bit si, input bit v, input logic [7:0] d,
                              input logic [6:0] a, output bit e_ready,
                              output bit e_busy, output bit e_rd_ok,
                              output logic [7:0] e_rd);
        bit edge_s;
        int mn, mx;
        edge_s = si && !m_si_prev;
        m_si_prev = si;
        e_ready = 0;
        e_rd_ok = m_rd_known;
        e_rd = m_rd[a];
        if (m_active && m_nacc == NPIX) begin
            m_rd = m_buf;
            m_rd_known = 1;
            m_lines++;
            e_ready = 1;
            m_active = 0;
            mn = 255;
            mx = 0;
            foreach (m_buf[i]) begin
                if (m_buf[i] < mn) mn = m_buf[i];
                if (m_buf[i] > mx) mx = m_buf[i];
            end
            m_min = mn;
            m_max = mx;
            m_thr = (mn + mx) / 2;
            if (edge_s) model_start();
        end else if (edge_s) begin
            if (m_active) model_abort();
            model_start();
        end else if (m_active) begin
            m_age++;
            if (m_age > SKIP) begin
                if (v) begin
                    m_buf[m_nacc] = d;
                    m_nacc++;
                    m_lows = 0;
                end else begin
                    m_lows++;
                    if (m_lows == TIMEOUT) begin
                        model_abort();
                        m_active = 0;
                    end
                end
            end
        end
        e_busy = m_active && (m_nacc < NPIX);
    endtask

    task automatic step(input bit si, input bit v, input logic [7:0] d);
        bit er, eb, eok;
        logic [7:0] ed;
        cam_si = si;
        adc_valid = v;
        adc_data = d;
        model_step(si, v, d, rd_addr, er, eb, eok, ed);
        @(posedge cam_clk);
        #1;
        chk("line_ready", 32'(line_ready), 32'(er));
        chk("busy", 32'(busy), 32'(eb));
        chk("line_cnt", 32'(line_cnt), 32'(m_lines & 16'hFFFF));
        chk("abort_cnt", 32'(abort_cnt), 32'(m_aborts));
        if (eok) chk("rd_data", 32'(rd_data), 32'(ed));
`ifdef CAM_MINMAX_EN
        chk("pix_min", 32'(pix_min), 32'(m_min));
        chk("pix_max", 32'(pix_max), 32'(m_max));
        chk("thresh", 32'(thresh), 32'(m_thr));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00);
    endtask

    // SI pulse followed by the skip window (valid held high there: must be ignored)
    task automatic start_si();
        step(1, 0, 8'h00);
        for (int i = 0; i < SKIP; i++) step(0, 1, 8'hEE);
    endtask

    // mode 0: constant base, 1: base+index, 2: random
    // gap 0: none, 3: every third cycle low, 4: random lows
    task automatic pixels(input int n, input int mode, input logic [7:0] base,
                          input int gap);
        int c = 0;
        int p = 0;
        logic [7:0] val;
        while (p < n) begin
            if ((gap == 3 && c % 3 == 2) || (gap == 4 && $urandom_range(0, 3) == 0)) begin
                step(0, 0, 8'($urandom));
            end else begin
                case (mode)
                    0: val = base;
                    1: val = base + 8'(p);
                    default: val = 8'($urandom);
                endcase
                step(0, 1, val);
                p++;
            end
            c++;
        end
    endtask

    task automatic readback();
        for (int a = 0; a < NPIX; a++) begin
            rd_addr = 7'(a);
            step(0, 0, 8'h00);
        end
    endtask

    task automatic do_reset();
        cam_si = 0;
        adc_valid = 0;
        rst_n = 0;
        #3;
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_line_ready", 32'(line_ready), 0);
        chk("rst_line_cnt", 32'(line_cnt), 0);
        chk("rst_abort_cnt", 32'(abort_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef CAM_MINMAX_EN
        chk("rst_pix_min", 32'(pix_min), 0);
        chk("rst_thresh", 32'(thresh), 0);
`endif
        model_reset();
        @(posedge cam_clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge cam_clk);
        #1;
        do_reset();

        // Basic line; with the SI-high cycle as cycle 0, line_ready is high
        // in cycle SKIP+1+NPIX+1 (checked per cycle by the model).
        step(0, 1, 8'hAA);
        start_si();
        pixels(NPIX, 1, 8'h00, 0);
        idle(3);
        chk("basic_line_cnt", 32'(line_cnt), 1);
        readback();

        // Same line with every third cycle a gap
        do_reset();
        start_si();
        pixels(NPIX, 1, 8'h00, 3);
        idle(3);
        chk("gap_abort_cnt", 32'(abort_cnt), 0);
        readback();

        // Random data with random gaps
        start_si();
        pixels(NPIX, 2, 8'h00, 4);
        idle(2);
        readback();

        // Early SI after 60 pixels, then a full 0xFF line
        do_reset();
        start_si();
        pixels(60, 2, 8'h00, 0);
        start_si();
        pixels(NPIX, 0, 8'hFF, 0);
        idle(2);
        chk("early_abort_cnt", 32'(abort_cnt), 1);
        chk("early_line_cnt", 32'(line_cnt), 1);
        readback();

        // Timeout: 10 pixels then valid stays low
        do_reset();
        start_si();
        pixels(10, 2, 8'h00, 0);
        idle(TIMEOUT - 1);
        chk("tmo_busy_before", 32'(busy), 1);
        idle(1);
        chk("tmo_busy_after", 32'(busy), 0);
        chk("tmo_abort_cnt", 32'(abort_cnt), 1);
        idle(3);
        start_si();
        pixels(NPIX, 2, 8'h00, 4);
        idle(2);
        chk("tmo_next_line_cnt", 32'(line_cnt), 1);
        readback();

        // SI edge on the completing cycle: swap happens, next line follows
        start_si();
        pixels(NPIX, 1, 8'h40, 0);
        step(1, 0, 8'h00);
        for (int i = 0; i < SKIP; i++) step(0, 1, 8'hEE);
        pixels(NPIX, 2, 8'h00, 0);
        idle(2);
        chk("done_si_abort_cnt", 32'(abort_cnt), 1);
        chk("done_si_line_cnt", 32'(line_cnt), 3);
        readback();

        // Ping-pong with rd_addr held at 5
        do_reset();
        rd_addr = 7'd5;
        start_si();
        pixels(NPIX, 0, 8'h11, 0);
        idle(2);
        chk("pp_old", 32'(rd_data), 32'h11);
        start_si();
        pixels(NPIX, 0, 8'h22, 4);
        idle(2);
        chk("pp_new", 32'(rd_data), 32'h22);

        // Min/max line then an aborted line
        start_si();
        pixels(NPIX, 1, 8'h10, 0);
        idle(2);
`ifdef CAM_MINMAX_EN
        chk("mm_min", 32'(pix_min), 32'h10);
        chk("mm_max", 32'(pix_max), 32'h8F);
        chk("mm_thresh", 32'(thresh), 32'h4F);
`endif
        start_si();
        pixels(20, 0, 8'h00, 0);
        pixels(20, 0, 8'hFF, 0);
        start_si();
        idle(TIMEOUT + 2);
`ifdef CAM_MINMAX_EN
        chk("mm_hold_min", 32'(pix_min), 32'h10);
        chk("mm_hold_thresh", 32'(thresh), 32'h4F);
`endif

        // Reset mid-line: everything clears, no line_ready
        start_si();
        pixels(50, 2, 8'h00, 0);
        adc_valid = 0;
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_ready", 32'(line_ready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_line_cnt", 32'(line_cnt), 0);
        chk("mid_rst_abort_cnt", 32'(abort_cnt), 0);
        chk("mid_rst_rd_data", 32'(rd_data), 0);
        model_reset();
        repeat (2) @(posedge cam_clk);
        #1;
        chk("mid_rst_ready_hold", 32'(line_ready), 0);
        rst_n = 1;
        idle(4);

        // abort_cnt saturation via repeated SI edges
        for (int i = 0; i < 260; i++) begin
            step(1, 0, 8'h00);
            step(0, 0, 8'h00);
        end
        chk("abort_sat", 32'(abort_cnt), 255);
        chk("abort_sat_lines", 32'(line_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end

endmodule
